// File: rtl/ascon_pkg.sv
// Shared Ascon state type and p_L rotation constants for the linear diffusion layer.
package ascon_pkg;

  localparam int unsigned WORD_W    = 64;
  localparam int unsigned NUM_WORDS = 5;

  // Word i lives at index i (x0..x4).
  typedef logic [NUM_WORDS-1:0][WORD_W-1:0] ascon_state_t;

  localparam int unsigned ROT_A [NUM_WORDS] = '{19, 61, 1, 10, 7};
  localparam int unsigned ROT_B [NUM_WORDS] = '{28, 39, 6, 17, 41};

endpackage

// File: rtl/linear_diffusion_sigma.sv
// Ascon per-word Sigma: x ^ ROR(x, ROT_A) ^ ROR(x, ROT_B). Pure wiring plus XOR.
module linear_diffusion_sigma
  import ascon_pkg::*;
#(
  parameter int unsigned ROT_A = 1,
  parameter int unsigned ROT_B = 2
) (
  input  logic [WORD_W-1:0] i_word,
  output logic [WORD_W-1:0] o_word
);

  logic [WORD_W-1:0] w_rot_a;
  logic [WORD_W-1:0] w_rot_b;

  assign w_rot_a = (i_word >> ROT_A) | (i_word << (WORD_W - ROT_A));
  assign w_rot_b = (i_word >> ROT_B) | (i_word << (WORD_W - ROT_B));
  assign o_word  = i_word ^ w_rot_a ^ w_rot_b;

endmodule

// File: rtl/linear_diffusion_layer.sv
// Ascon p_L linear diffusion layer. Combinational by default; define
// LINEAR_DIFFUSION_OUTPUT_REG_EN for a 1-cycle registered output stage.
module linear_diffusion_layer
  import ascon_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  input  ascon_state_t state_array_i,
  output logic         valid_o,
  output ascon_state_t state_array_o
);

  ascon_state_t w_state;

  for (genvar g = 0; g < NUM_WORDS; g++) begin : g_sigma
    linear_diffusion_sigma #(
      .ROT_A (ROT_A[g]),
      .ROT_B (ROT_B[g])
    ) u_sigma (
      .i_word (state_array_i[g]),
      .o_word (w_state[g])
    );
  end

`ifdef LINEAR_DIFFUSION_OUTPUT_REG_EN
  ascon_state_t r_state;
  logic         r_valid;

  // Data only loads on valid so the output holds between results.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= valid_i;
      if (valid_i) begin
        r_state <= w_state;
      end
    end
  end

  assign state_array_o = r_state;
  assign valid_o       = r_valid;
`else
  logic w_unused;

  assign w_unused      = clk_i | rst_i;
  assign state_array_o = w_state;
  assign valid_o       = valid_i;
`endif

endmodule

// File: tb/tb_linear_diffusion_layer.sv
// Self-checking bench for linear_diffusion_layer against a bitwise reference model;
// covers both builds (LINEAR_DIFFUSION_OUTPUT_REG_EN selects registered timing checks).
module tb_linear_diffusion_layer;

  typedef logic [4:0][63:0] st_t;

  logic clk = 1'b0;
  logic rst_i;
  logic valid_i;
  logic valid_o;
  st_t  state_in;
  st_t  state_out;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  st_t  exp_state = '0;
  logic exp_valid = 1'b0;

  always #5 clk = ~clk;

  linear_diffusion_layer dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .valid_i       (valid_i),
    .state_array_i (state_in),
    .valid_o       (valid_o),
    .state_array_o (state_out)
  );

  // Output bit j of word w is input bits j, j+A, j+B (mod 64) of the same word.
  function automatic st_t ref_f(input st_t s);
    int ra [5] = '{19, 61, 1, 10, 7};
    int rb [5] = '{28, 39, 6, 17, 41};
    st_t r;
    for (int w = 0; w < 5; w++)
      for (int j = 0; j < 64; j++)
        r[w][j] = s[w][j] ^ s[w][(j + ra[w]) % 64] ^ s[w][(j + rb[w]) % 64];
    return r;
  endfunction

  function automatic st_t rand_state();
    st_t s;
    for (int w = 0; w < 5; w++) s[w] = {$urandom(), $urandom()};
    return s;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs and advance the reference expectation.
  task automatic step(input logic r, input logic v, input st_t d);
    @(negedge clk);
    rst_i    = r;
    valid_i  = v;
    state_in = d;
    @(posedge clk);
    #1;
`ifdef LINEAR_DIFFUSION_OUTPUT_REG_EN
    if (r) begin
      exp_state = '0;
      exp_valid = 1'b0;
    end else begin
      exp_valid = v;
      if (v) exp_state = ref_f(d);
    end
`else
    exp_state = ref_f(d);
    exp_valid = v;
`endif
  endtask

  task automatic check_out(input string tag);
    for (int w = 0; w < 5; w++)
      check($sformatf("%s_w%0d", tag, w), state_out[w], exp_state[w]);
    check({tag, "_valid"}, {63'd0, valid_o}, {63'd0, exp_valid});
  endtask

  initial begin
    st_t a, b, c, onehot, ones;
    logic [63:0] bit_exp [5];
    bit_exp[0] = 64'h0000_2010_0000_0001;
    bit_exp[1] = 64'h0000_0000_0200_0009;
    bit_exp[2] = 64'h8400_0000_0000_0001;
    bit_exp[3] = 64'h0040_8000_0000_0001;
    bit_exp[4] = 64'h0200_0000_0080_0001;

    rst_i = 1'b1; valid_i = 1'b0; state_in = '0;

    // Reset state (registered build clears; combinational build follows input).
    step(1'b1, 1'b0, rand_state());
    check_out("reset");
    step(1'b0, 1'b0, '0);

    step(1'b0, 1'b1, '0);
    check_out("zeros");
    for (int w = 0; w < 5; w++) check($sformatf("zeros_lit_w%0d", w), state_out[w], 64'd0);

    for (int i = 0; i < 5; i++) begin
      onehot = '0;
      onehot[i] = 64'd1;
      step(1'b0, 1'b1, onehot);
      for (int w = 0; w < 5; w++)
        check($sformatf("bit%0d_w%0d", i, w), state_out[w], (w == i) ? bit_exp[i] : 64'd0);
    end

    ones = '1;
    step(1'b0, 1'b1, ones);
    for (int w = 0; w < 5; w++)
      check($sformatf("ones_w%0d", w), state_out[w], 64'hFFFF_FFFF_FFFF_FFFF);

    for (int n = 0; n < 500; n++) begin
      a = rand_state();
      b = rand_state();
      step(1'b0, 1'b1, a);
      check_out("rand_a");
      step(1'b0, 1'b1, b);
      check_out("rand_b");
      c = ref_f(a) ^ ref_f(b);
      step(1'b0, 1'b1, a ^ b);
      for (int w = 0; w < 5; w++)
        check($sformatf("linear_w%0d", w), state_out[w], c[w]);
    end

    // valid_i low: registered build holds data, combinational build still computes.
    a = rand_state();
    step(1'b0, 1'b1, a);
    check_out("pre_hold");
    step(1'b0, 1'b0, rand_state());
    check_out("hold");
    step(1'b0, 1'b0, rand_state());
    check_out("hold2");

`ifdef LINEAR_DIFFUSION_OUTPUT_REG_EN
    // Reset beats a simultaneous valid input.
    step(1'b1, 1'b1, rand_state());
    check_out("rst_valid");
    for (int w = 0; w < 5; w++) check($sformatf("rst_lit_w%0d", w), state_out[w], 64'd0);
    check("rst_lit_valid", {63'd0, valid_o}, 64'd0);
    step(1'b0, 1'b0, rand_state());
    check_out("post_rst_idle");
    // Back-to-back stream: each result appears exactly one edge after its input.
    for (int k = 0; k < 8; k++) begin
      a = rand_state();
      step(1'b0, 1'b1, a);
      c = ref_f(a);
      for (int w = 0; w < 5; w++)
        check($sformatf("stream%0d_w%0d", k, w), state_out[w], c[w]);
      check($sformatf("stream%0d_valid", k), {63'd0, valid_o}, 64'd1);
    end
    step(1'b0, 1'b0, '0);
    check_out("stream_end");
`else
    // Zero latency: output follows input within the same cycle.
    a = rand_state();
    @(negedge clk);
    valid_i  = 1'b1;
    state_in = a;
    #1;
    c = ref_f(a);
    for (int w = 0; w < 5; w++) check($sformatf("comb_w%0d", w), state_out[w], c[w]);
    check("comb_valid", {63'd0, valid_o}, 64'd1);
    valid_i = 1'b0;
    #1;
    check("comb_valid_lo", {63'd0, valid_o}, 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
